fsm_seq_monitor: RTL
====================

# fsm_seq_monitor

Runtime checker placed directly downstream of the 4-state sequencer (`control` in, 2-bit state code `y` out). It samples the sequencer's `y` and `control` every cycle and checks each transition against the legal graph 0→1, 1→(control ? 3 : 2), 2→3, 3→0. It counts completed short (0-1-3-0) and long (0-1-2-3-0) loops and latches the first illegal transition as a sticky fault. It is intended for simulation and on-chip debug visibility of Moore-output sequencers.

## Interface
- `CNT_WIDTH`, default 8: width of each loop counter; counters saturate at 2^CNT_WIDTH-1.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `control` in 1: same signal driven into the sequencer; only meaningful in the cycle where `y`==1.
- `y` in 2: sequencer state/output code.
- `clear` in 1: synchronous, active-high soft clear of counters and fault.
- `in_sync` out 1: 1 while the monitor is tracking (state TRACK).
- `err` out 1: sticky fault flag.
- `err_code` out 4: {previous y, offending y} of the first illegal transition.
- `loop_done` out 1: one-cycle pulse per completed loop.
- `short_cnt` out CNT_WIDTH: completed 0-1-3-0 loops.
- `long_cnt` out CNT_WIDTH: completed 0-1-2-3-0 loops.

## Operation
- Registered state: `mon_state` ∈ {WAIT_SYNC, TRACK, FAULT}, `prev_y[1:0]`, `prev_ctl`, `path_long`, plus the output registers.
- WAIT_SYNC (reset state): when `y`==0 is sampled, go to TRACK, set `prev_y`=0, `path_long`=0. No count and no check.
- TRACK: expected y = f(`prev_y`, `prev_ctl`): 0→1, 1→(`prev_ctl` ? 3 : 2), 2→3, 3→0.
  - Match: `prev_y`←`y`, `prev_ctl`←`control`. On 1→2, set `path_long`=1. On 1→3, set `path_long`=0.
  - Match on 3→0: increment `long_cnt` if `path_long`, else `short_cnt`. Pulse `loop_done`. Clear `path_long`.
  - Mismatch, including a y that holds for 2 cycles: go to FAULT, `err`=1, `err_code`={`prev_y`, `y`}. Counters are not updated on that edge.
- FAULT: holds `err`, `err_code` and the counters. Ignores `y`/`control`. Leaves only via `clear` or `reset`.
- `clear` (any state): zeroes counters, `err`, `err_code`, `loop_done`, `path_long`; goes to WAIT_SYNC. If a mismatch occurs on the same edge, `clear` wins and no fault is recorded.
- Saturation: a counter at all-ones stays all-ones. `loop_done` still pulses.
- Only the first fault is recorded; later transitions cannot overwrite `err_code`.
- `control` is only captured into `prev_ctl`. Its value is irrelevant except in the cycle `y`==1.

## Timing
- Reset values: `in_sync`=0, `err`=0, `err_code`=4'h0, `loop_done`=0, `short_cnt`=0, `long_cnt`=0, `mon_state`=WAIT_SYNC.
- All outputs are registered. The effect of the `y` sampled at edge N is visible after edge N.
- `in_sync` rises after the edge that samples the first `y`==0.
- `loop_done` and the counter increment appear after the edge that samples `y`==0 following `y`==3. The pulse lasts exactly one cycle.
- `err` rises after the edge that samples the illegal `y`.
- Reset mid-loop: the monitor returns to WAIT_SYNC and discards the partial loop. If the sequencer is reset together with the monitor, it emits 0 and the monitor resyncs on the first post-reset edge.
- No throughput limit: one transition is checked per cycle. There are no bubbles.

## Test plan
- Reset, then sequencer with `control`=0 for 3 full loops → `long_cnt`=3, `short_cnt`=0, 3 `loop_done` pulses spaced 4 cycles apart, `err`=0.
- `control`=1 during every `y`==1 for 5 loops → `short_cnt`=5, pulses spaced 3 cycles apart. Alternating `control` over 4 loops → 2 short, 2 long.
- Force `y` 1→2 while `control`=1 → `err`=1, `err_code`=4'b0110, `in_sync`=0, counters frozen. A later 2→0 does not change `err_code`.
- Force `y` to hold at 2 for 2 cycles → `err_code`=4'b1010. Then `clear` → `err`=0, counters 0, resync on next `y`==0. Assert `clear` on the same edge as an illegal `y` → `err` stays 0.
- `CNT_WIDTH`=2, 5 long loops → `long_cnt`=3 (saturated), 5 `loop_done` pulses.
- Assert `reset` while `y`==2 mid-loop → all outputs 0 on the next cycle. The loop is not counted after resync.

Source files
------------

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor: runtime checker for a 4-state Moore sequencer.
// Ports: clk, reset (sync, active-high), control, y[1:0], clear (soft clear);
//   in_sync, err, err_code[3:0], loop_done, short_cnt, long_cnt (all registered).
module fsm_seq_monitor #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 control,
    input  logic [1:0]           y,
    input  logic                 clear,
    output logic                 in_sync,
    output logic                 err,
    output logic [3:0]           err_code,
    output logic                 loop_done,
    output logic [CNT_WIDTH-1:0] short_cnt,
    output logic [CNT_WIDTH-1:0] long_cnt
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        TRACK     = 2'd1,
        FAULT     = 2'd2
    } mon_state_t;

    mon_state_t           mon_state, state_n;
    logic [1:0]           prev_y, prev_y_n;
    logic                 prev_ctl, prev_ctl_n;
    logic                 path_long, path_long_n;
    logic                 err_n;
    logic [3:0]           err_code_n;
    logic                 loop_done_n;
    logic [CNT_WIDTH-1:0] short_n, long_n;
    logic [1:0]           exp_y;

    // Decoded from the state register, so it is glitch-free like the others.
    assign in_sync = (mon_state == TRACK);

    // Legal successor of the previously sampled code.
    always_comb begin
        exp_y = 2'd0;
        unique case (prev_y)
            2'd0: exp_y = 2'd1;
            2'd1: exp_y = prev_ctl ? 2'd3 : 2'd2;
            2'd2: exp_y = 2'd3;
            2'd3: exp_y = 2'd0;
            default: exp_y = 2'd0;
        endcase
    end

    always_comb begin
        state_n     = mon_state;
        prev_y_n    = prev_y;
        prev_ctl_n  = prev_ctl;
        path_long_n = path_long;
        err_n       = err;
        err_code_n  = err_code;
        loop_done_n = 1'b0;
        short_n     = short_cnt;
        long_n      = long_cnt;

        if (clear) begin
            // Clear overrides any fault detected on the same edge.
            state_n     = WAIT_SYNC;
            path_long_n = 1'b0;
            err_n       = 1'b0;
            err_code_n  = 4'h0;
            short_n     = '0;
            long_n      = '0;
        end else begin
            unique case (mon_state)
                WAIT_SYNC: begin
                    if (y == 2'd0) begin
                        state_n     = TRACK;
                        prev_y_n    = 2'd0;
                        prev_ctl_n  = control;
                        path_long_n = 1'b0;
                    end
                end
                TRACK: begin
                    if (y == exp_y) begin
                        prev_y_n   = y;
                        prev_ctl_n = control;
                        if (prev_y == 2'd1) begin
                            path_long_n = (y == 2'd2);
                        end
                        if (prev_y == 2'd3) begin
                            loop_done_n = 1'b1;
                            path_long_n = 1'b0;
                            if (path_long) begin
                                if (~&long_cnt) long_n = long_cnt + CNT_WIDTH'(1);
                            end else begin
                                if (~&short_cnt) short_n = short_cnt + CNT_WIDTH'(1);
                            end
                        end
                    end else begin
                        state_n    = FAULT;
                        err_n      = 1'b1;
                        err_code_n = {prev_y, y};
                    end
                end
                FAULT: begin
                    // Frozen until clear or reset.
                end
                default: state_n = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mon_state <= WAIT_SYNC;
            prev_y    <= 2'd0;
            prev_ctl  <= 1'b0;
            path_long <= 1'b0;
            err       <= 1'b0;
            err_code  <= 4'h0;
            loop_done <= 1'b0;
            short_cnt <= '0;
            long_cnt  <= '0;
        end else begin
            mon_state <= state_n;
            prev_y    <= prev_y_n;
            prev_ctl  <= prev_ctl_n;
            path_long <= path_long_n;
            err       <= err_n;
            err_code  <= err_code_n;
            loop_done <= loop_done_n;
            short_cnt <= short_n;
            long_cnt  <= long_n;
        end
    end

endmodule
